// File: rtl/dcache_pkg.sv
// Shared geometry, FSM encoding and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int LINES  = 8;
    localparam int WORDS  = 4;
    localparam int ADDR_W = 12;

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        REFILL  = 2'd2,
        WRITE   = 2'd3
    } state_t;

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return a[OFF_W-1:0];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: one line looked up combinationally, byte-lane data writes,
// valid bits cleared on reset while tags and data are left untouched.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [IDX_W-1:0]       idx,
    output logic                   line_valid,
    output logic [TAG_W-1:0]       line_tag,
    output logic [WORDS*32-1:0]    line_data,
    input  logic                   wr_en,
    input  logic [OFF_W-1:0]       wr_off,
    input  logic [3:0]             wr_be,
    input  logic [31:0]            wr_data,
    input  logic                   tag_set,
    input  logic [TAG_W-1:0]       tag_data,
    input  logic                   inv
);

    logic [LINES-1:0] valid_reg;
    logic [TAG_W-1:0] tag_mem [LINES];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_reg <= '0;
        end else if (tag_set) begin
            valid_reg[idx] <= 1'b1;
        end else if (inv) begin
            valid_reg[idx] <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (tag_set) begin
            tag_mem[idx] <= tag_data;
        end
    end

    assign line_valid = valid_reg[idx];
    assign line_tag   = tag_mem[idx];

    // One byte-wide array per lane so each byte enable gates only its own lane.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] byte_mem [LINES*WORDS];

            always_ff @(posedge CLK) begin
                if (wr_en && wr_be[gi]) begin
                    byte_mem[{idx, wr_off}] <= wr_data[8*gi +: 8];
                end
            end

            for (genvar gw = 0; gw < WORDS; gw++) begin : g_word
                assign line_data[32*gw + 8*gi +: 8] = byte_mem[{idx, OFF_W'(gw)}];
            end
        end
    endgenerate

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache between CPU and data memory.
// Define DCACHE_PERF_CNT_EN to add the HIT_CNT / MISS_CNT outputs.
module dcache_responder
    import dcache_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              Cache_CSN,
    input  logic              Cache_WEN,
    input  logic [ADDR_W-1:0] Cache_ADDR,
    input  logic [3:0]        Cache_BE,
    input  logic [31:0]       Cache_DI,
    output logic [31:0]       Cache_DOUT,
    output logic              RDY,
    output logic              VALID,
    output logic              D_MEM_CSN,
    output logic              D_MEM_WEN,
    output logic [ADDR_W-1:0] D_MEM_ADDR,
    output logic [3:0]        D_MEM_BE,
    output logic [31:0]       D_MEM_DOUT,
    input  logic [31:0]       D_MEM_DI
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]       HIT_CNT,
    output logic [31:0]       MISS_CNT
`endif
);

    localparam logic [OFF_W:0] CNT_LAST = (OFF_W+1)'(WORDS);

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              wen_reg;
    logic [3:0]        be_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       dout_reg;
    logic [OFF_W:0]    cnt_reg;

    logic [ADDR_W-1:0] addr_sel;
    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [WORDS*32-1:0] line_data;
    logic              hit;
    logic [31:0]       sel_word;
    logic [31:0]       fill_word;
    logic              refill_last;
    logic              refill_req;
    logic              arr_we;
    logic [OFF_W-1:0]  arr_off;
    logic [3:0]        arr_be;
    logic [31:0]       arr_wdata;

    // In IDLE the lookup follows the live CPU address so a read hit can load
    // Cache_DOUT at the accepting edge and present it together with VALID.
    assign addr_sel    = (state_reg == IDLE) ? Cache_ADDR : addr_reg;
    assign hit         = line_valid && (line_tag == addr_tag(addr_sel));
    assign sel_word    = line_data[32*addr_off(addr_sel) +: 32];
    assign refill_last = (state_reg == REFILL) && (cnt_reg == CNT_LAST);
    assign refill_req  = (state_reg == REFILL) && (cnt_reg < CNT_LAST);
    assign fill_word   = (addr_off(addr_reg) == OFF_W'(WORDS-1)) ? D_MEM_DI : sel_word;

    always_comb begin
        arr_we    = 1'b0;
        arr_off   = addr_off(addr_reg);
        arr_be    = be_reg;
        arr_wdata = wdata_reg;
        if (state_reg == REFILL) begin
            arr_we    = (cnt_reg != '0);
            arr_off   = OFF_W'(cnt_reg - 1'b1);
            arr_be    = 4'hF;
            arr_wdata = D_MEM_DI;
        end else if ((state_reg == COMPARE) && !wen_reg && hit) begin
            arr_we = 1'b1;
        end
    end

    dcache_array u_array (
        .CLK        (CLK),
        .RST        (RST),
        .idx        (addr_idx(addr_sel)),
        .line_valid (line_valid),
        .line_tag   (line_tag),
        .line_data  (line_data),
        .wr_en      (arr_we),
        .wr_off     (arr_off),
        .wr_be      (arr_be),
        .wr_data    (arr_wdata),
        .tag_set    (refill_last),
        .tag_data   (addr_tag(addr_reg)),
        .inv        ((state_reg == REFILL) && (cnt_reg == '0))
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            wen_reg   <= 1'b1;
            be_reg    <= '0;
            wdata_reg <= '0;
            dout_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!Cache_CSN) begin
                        addr_reg  <= Cache_ADDR;
                        wen_reg   <= Cache_WEN;
                        be_reg    <= Cache_BE;
                        wdata_reg <= Cache_DI;
                        if (Cache_WEN && hit) begin
                            dout_reg <= sel_word;
                        end
                        state_reg <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (!wen_reg) begin
                        state_reg <= WRITE;
                    end else if (hit) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg   <= '0;
                        state_reg <= REFILL;
                    end
                end
                REFILL: begin
                    if (refill_last) begin
                        dout_reg  <= fill_word;
                        state_reg <= COMPARE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                WRITE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs are decoded from state so a reset drops them at once.
    assign RDY        = (state_reg == IDLE);
    assign VALID      = ((state_reg == COMPARE) && wen_reg && hit) || (state_reg == WRITE);
    assign Cache_DOUT = dout_reg;
    assign D_MEM_CSN  = !(refill_req || (state_reg == WRITE));
    assign D_MEM_WEN  = !(state_reg == WRITE);
    assign D_MEM_BE   = (state_reg == WRITE) ? be_reg : 4'h0;
    assign D_MEM_DOUT = (state_reg == WRITE) ? wdata_reg : 32'h0;
    assign D_MEM_ADDR = refill_req ? {addr_tag(addr_reg), addr_idx(addr_reg), cnt_reg[OFF_W-1:0]}
                      : (state_reg == WRITE) ? addr_reg : '0;

`ifdef DCACHE_PERF_CNT_EN
    logic        first_reg;
    logic [31:0] hit_cnt_reg;
    logic [31:0] miss_cnt_reg;

    // Only the first COMPARE of a request counts; the post-refill COMPARE is skipped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            first_reg    <= 1'b0;
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else begin
            if ((state_reg == IDLE) && !Cache_CSN) begin
                first_reg <= 1'b1;
            end else if (state_reg == COMPARE) begin
                first_reg <= 1'b0;
            end
            if ((state_reg == COMPARE) && first_reg) begin
                if (hit) begin
                    hit_cnt_reg <= hit_cnt_reg + 32'd1;
                end else begin
                    miss_cnt_reg <= miss_cnt_reg + 32'd1;
                end
            end
        end
    end

    assign HIT_CNT  = hit_cnt_reg;
    assign MISS_CNT = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: memory model, cache tag model and read-data scoreboard.
module tb_dcache_responder;

    localparam int WORDS_TB = 4;
    localparam int BOUND    = 20;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Cache_CSN;
    logic        Cache_WEN;
    logic [11:0] Cache_ADDR;
    logic [3:0]  Cache_BE;
    logic [31:0] Cache_DI;
    logic [31:0] Cache_DOUT;
    logic        RDY;
    logic        VALID;
    logic        D_MEM_CSN;
    logic        D_MEM_WEN;
    logic [11:0] D_MEM_ADDR;
    logic [3:0]  D_MEM_BE;
    logic [31:0] D_MEM_DOUT;
    logic [31:0] D_MEM_DI;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] HIT_CNT;
    logic [31:0] MISS_CNT;
`endif

    dcache_responder dut (
        .CLK        (CLK),
        .RST        (RST),
        .Cache_CSN  (Cache_CSN),
        .Cache_WEN  (Cache_WEN),
        .Cache_ADDR (Cache_ADDR),
        .Cache_BE   (Cache_BE),
        .Cache_DI   (Cache_DI),
        .Cache_DOUT (Cache_DOUT),
        .RDY        (RDY),
        .VALID      (VALID),
        .D_MEM_CSN  (D_MEM_CSN),
        .D_MEM_WEN  (D_MEM_WEN),
        .D_MEM_ADDR (D_MEM_ADDR),
        .D_MEM_BE   (D_MEM_BE),
        .D_MEM_DOUT (D_MEM_DOUT),
        .D_MEM_DI   (D_MEM_DI)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .HIT_CNT    (HIT_CNT),
        .MISS_CNT   (MISS_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_val(input logic [11:0] a);
        if (a >= 12'h010 && a <= 12'h013) return 32'(a - 12'h00F);
        return {20'hC0DE0, a};
    endfunction

    // Synchronous word memory: read data appears the cycle after the address.
    logic [31:0] mem [4096];
    logic        mem_init;
    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_val(12'(i));
        end else if (!D_MEM_CSN) begin
            if (D_MEM_WEN) begin
                D_MEM_DI <= mem[D_MEM_ADDR];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (D_MEM_BE[b]) mem[D_MEM_ADDR][8*b +: 8] <= D_MEM_DOUT[8*b +: 8];
            end
        end
    end

    logic [31:0] exp_mem [4096];
    logic        exp_v [8];
    logic [6:0]  exp_t [8];
    logic [31:0] sb_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string nm, input logic wr, input logic [11:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        logic [2:0]  ix;
        logic [6:0]  tg;
        logic        hit;
        logic        miss;
        logic        active;
        logic [11:0] eaddr;
        logic [31:0] exp_dout;
        int          lat_exp;
        int          n;
        ix   = a[4:2];
        tg   = a[11:5];
        hit  = exp_v[ix] && (exp_t[ix] == tg);
        miss = !wr && !hit;
        lat_exp = wr ? 2 : (hit ? 1 : WORDS_TB + 3);
        if (!wr) sb_q.push_back(exp_mem[a]);

        n = 0;
        while (!RDY && n < BOUND) begin
            @(negedge CLK);
            n++;
        end
        chk({nm, " rdy"}, RDY, 1);
        Cache_CSN  = 1'b0;
        Cache_WEN  = !wr;
        Cache_ADDR = a;
        Cache_BE   = be;
        Cache_DI   = wd;
        @(posedge CLK);
        #1;
        // Garbage on the bus outside IDLE must be ignored.
        Cache_CSN  = 1'b1;
        Cache_WEN  = wr;
        Cache_ADDR = ~a;
        Cache_BE   = ~be;
        Cache_DI   = ~wd;

        n = 0;
        do begin
            @(negedge CLK);
            n++;
            active = miss ? (n >= 2 && n <= WORDS_TB + 1) : (wr && n == 2);
            chk({nm, " mem_csn"}, D_MEM_CSN, !active);
            if (active && D_MEM_CSN === 1'b0) begin
                eaddr = miss ? {a[11:2], 2'(n - 2)} : a;
                chk({nm, " mem_addr"}, D_MEM_ADDR, eaddr);
                chk({nm, " mem_wen"}, D_MEM_WEN, !wr);
                if (wr) begin
                    chk({nm, " mem_be"}, D_MEM_BE, be);
                    chk({nm, " mem_dout"}, D_MEM_DOUT, wd);
                end
            end
        end while (VALID !== 1'b1 && n < BOUND);
        chk({nm, " latency"}, n, lat_exp);
        chk({nm, " busy"}, RDY, 0);
        if (!wr) begin
            exp_dout = sb_q.pop_front();
            chk({nm, " dout"}, Cache_DOUT, exp_dout);
        end

        if (miss) begin
            exp_v[ix] = 1'b1;
            exp_t[ix] = tg;
        end
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) exp_mem[a][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4096; i++) exp_mem[i] = init_val(12'(i));
        for (int i = 0; i < 8; i++) begin
            exp_v[i] = 1'b0;
            exp_t[i] = '0;
        end
        RST        = 1'b1;
        mem_init   = 1'b1;
        Cache_CSN  = 1'b1;
        Cache_WEN  = 1'b1;
        Cache_ADDR = '0;
        Cache_BE   = '0;
        Cache_DI   = '0;
        #1;
        chk("reset rdy", RDY, 1);
        chk("reset valid", VALID, 0);
        chk("reset dout", Cache_DOUT, 0);
        chk("reset mem_csn", D_MEM_CSN, 1);
        chk("reset mem_wen", D_MEM_WEN, 1);
        chk("reset mem_be", D_MEM_BE, 0);
        chk("reset mem_addr", D_MEM_ADDR, 0);
        chk("reset mem_dout", D_MEM_DOUT, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        mem_init = 1'b0;
        RST      = 1'b0;
        @(negedge CLK);

        do_req("rd_miss_010", 1'b0, 12'h010, 4'h0, 32'h0);
        do_req("rd_hit_012",  1'b0, 12'h012, 4'h0, 32'h0);
        do_req("wr_hit_011",  1'b1, 12'h011, 4'b0011, 32'hAABBCCDD);
        do_req("rd_hit_011",  1'b0, 12'h011, 4'h0, 32'h0);
        do_req("wr_miss_090", 1'b1, 12'h090, 4'hF, 32'h12345678);
        do_req("rd_hit_010",  1'b0, 12'h010, 4'h0, 32'h0);
        do_req("rd_miss_090", 1'b0, 12'h090, 4'h0, 32'h0);
        do_req("rd_evict_010", 1'b0, 12'h010, 4'h0, 32'h0);
        do_req("wr_be0_012",  1'b1, 12'h012, 4'h0, 32'hDEADBEEF);
        do_req("rd_be0_012",  1'b0, 12'h012, 4'h0, 32'h0);
        do_req("wr_hi_013",   1'b1, 12'h013, 4'b1100, 32'h9876FFFF);
        do_req("rd_hi_013",   1'b0, 12'h013, 4'h0, 32'h0);
        do_req("rd_miss_fff", 1'b0, 12'hFFF, 4'h0, 32'h0);
        do_req("rd_hit_ffc",  1'b0, 12'hFFC, 4'h0, 32'h0);

        // Reset in the third refill cycle of a miss on 0x090.
        while (!RDY) @(negedge CLK);
        Cache_CSN  = 1'b0;
        Cache_WEN  = 1'b1;
        Cache_ADDR = 12'h090;
        @(posedge CLK);
        #1;
        Cache_CSN = 1'b1;
        repeat (4) @(negedge CLK);
        chk("rst_mid pre csn", D_MEM_CSN, 0);
        chk("rst_mid pre addr", D_MEM_ADDR, 12'h092);
        RST = 1'b1;
        #1;
        chk("rst_mid csn", D_MEM_CSN, 1);
        chk("rst_mid rdy", RDY, 1);
        chk("rst_mid valid", VALID, 0);
        chk("rst_mid addr", D_MEM_ADDR, 0);
`ifdef DCACHE_PERF_CNT_EN
        chk("rst_mid hit_cnt", HIT_CNT, 0);
        chk("rst_mid miss_cnt", MISS_CNT, 0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 8; i++) exp_v[i] = 1'b0;
        @(negedge CLK);

        do_req("post_rst_010", 1'b0, 12'h010, 4'h0, 32'h0);
`ifdef DCACHE_PERF_CNT_EN
        chk("perf hit_cnt", HIT_CNT, 0);
        chk("perf miss_cnt", MISS_CNT, 1);
`endif
        do_req("post_rst_090", 1'b0, 12'h090, 4'h0, 32'h0);
        do_req("post_rst_093", 1'b0, 12'h093, 4'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Responder end of the CPU data-cache interface: the direct-mapped, write-through, no-write-allocate data cache between the CPU core and the word-addressed synchronous data memory.
- The CPU drives the request (Cache_CSN/WEN/ADDR/BE/DI).
- The cache returns read data plus the RDY/VALID handshake, and issues D_MEM transactions on misses and on every write.

Parameters:
- LINES, 8, number of cache lines (power of 2).
- WORDS, 4, 32-bit words per line (power of 2).
- ADDR_W, 12, word-address width on both the CPU side and the memory side.

Ports:
- CLK  in  1  clock, all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Cache_CSN  in  1  request strobe, active-low.
- Cache_WEN  in  1  0 = write, 1 = read.
- Cache_ADDR  in  ADDR_W  word address.
- Cache_BE  in  4  byte enables, active-high, bit i = byte i.
- Cache_DI  in  32  write data.
- Cache_DOUT  out  32  read data, registered.
- RDY  out  1  cache idle, accepts a request this cycle.
- VALID  out  1  one-cycle pulse: read data valid or write done.
- D_MEM_CSN  out  1  memory select, active-low.
- D_MEM_WEN  out  1  memory write, active-low.
- D_MEM_ADDR  out  ADDR_W  memory word address.
- D_MEM_BE  out  4  memory byte enables, active-high.
- D_MEM_DOUT  out  32  memory write data.
- D_MEM_DI  in  32  memory read data, valid the cycle after an address is presented with CSN=0 and WEN=1.

Behaviour:
- Address split: offset = ADDR[log2(WORDS)-1:0]; index = next log2(LINES) bits; tag = remaining bits (7 at defaults).
- Storage: tag and valid bit per line; data array with byte-writable words.
- Reset (async): state IDLE, all valid bits cleared, refill counter 0.
  - Output values in reset: RDY=1, VALID=0, Cache_DOUT=0, D_MEM_CSN=1, D_MEM_WEN=1, D_MEM_BE=0, D_MEM_ADDR=0, D_MEM_DOUT=0.
  - Data and tag arrays are not reset.
- FSM states: IDLE, COMPARE, REFILL, WRITE.
- IDLE (RDY=1):
  - A rising edge with Cache_CSN=0 latches addr/wen/be/wdata and moves to COMPARE.
  - RDY=0 in every other state; CPU inputs are ignored outside IDLE (the latched copies are used).
- COMPARE, read:
  - Hit: Cache_DOUT <= word, VALID=1 for this cycle, -> IDLE.
  - Miss: -> REFILL.
- COMPARE, write:
  - Hit: merge wdata into the line under BE.
  - Hit or miss: -> WRITE. A write miss does not allocate.
- REFILL, counter c = 0..WORDS:
  - For c < WORDS: D_MEM_CSN=0, WEN=1, ADDR = {tag,index,c}.
  - For c >= 1: capture D_MEM_DI into word c-1.
  - At c = WORDS: set tag, set valid, -> COMPARE (which then hits).
- Read latency from the accepting edge E0:
  - Hit: VALID in the cycle after E0.
  - Miss (WORDS=4): VALID in the cycle after E6.
- WRITE (one cycle): D_MEM_CSN=0, WEN=0, ADDR = latched addr, BE = latched BE, DOUT = latched wdata; VALID=1; -> IDLE.
- Boundary rules:
  - BE=0 write: memory write still issued with BE=0; array unchanged.
  - Back-to-back requests: a new request is accepted at the first edge in IDLE after VALID.
  - Reset during REFILL or WRITE: the memory request drops immediately (outputs are decoded from state); the partial line stays invalid.
  - Index wrap: the highest address 0xFFF maps to the last line / last offset with no overflow.

Optional Feature:
- Macro: DCACHE_PERF_CNT_EN.
- Defined: adds outputs HIT_CNT[31:0] and MISS_CNT[31:0].
  - Each increments once per request in its first COMPARE cycle (hit vs miss; the post-refill COMPARE is not counted).
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg holds:
  - the state encoding (IDLE/COMPARE/REFILL/WRITE);
  - localparams OFF_W, IDX_W, TAG_W derived from LINES/WORDS/ADDR_W;
  - the address-field extraction functions.
- Sub-module dcache_array: tag/valid/data storage with byte-enable write port, refill word write, valid-clear on RST, and a combinational read of the indexed line.

Test Plan:
- Reset, read 0x010 (mem[0x010..0x013]=1,2,3,4) -> D_MEM reads 0x010..0x013 in consecutive cycles; VALID in the cycle after E6; Cache_DOUT=1.
- Then read 0x012 -> VALID in the cycle after acceptance; Cache_DOUT=3; D_MEM_CSN stays 1.
- Write 0x011 data 0xAABBCCDD BE=4'b0011 (hit) -> one D_MEM write, BE=0011; read 0x011 -> 0x0000CCDD.
- Write miss 0x090 (same index as 0x010, tag 4) -> single D_MEM write, no refill; read 0x010 still hits.
- Read 0x090 -> refill evicts the line; next read 0x010 misses again and refills from 0x010.
- Assert RST at the third REFILL cycle -> D_MEM_CSN=1, RDY=1, VALID=0 immediately; after release, read 0x010 misses; with DCACHE_PERF_CNT_EN, HIT_CNT=0 and MISS_CNT=1.
